// File: rtl/l1_tlb.sv
// l1_tlb: small fully-associative first-level TLB in front of the shared l2_tlb.
// A miss sends one query to l2_tlb, installs the returned entry into the
// round-robin victim slot, and then replays the lookup on the latched address.
module l1_tlb #(
  parameter int ENTRIES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [31:0] req_vaddr,
  input  logic        req_store,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_paddr,
  output logic [2:0]  resp_cattr,
  output logic [1:0]  resp_exc,
  input  logic [7:0]  cp0_asid,
  input  logic [2:0]  cp0_k0,
  input  logic        tlbw_flush,
  output logic        l2_qry_en,
  output logic [31:0] l2_qry_vaddr,
  input  logic [78:0] l2_qry_tlb,
  input  logic        l2_qry_isexist,
  input  logic        l2_qry_done
);
  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {IDLE, QUERY, WAIT, REPLAY} state_t;

  state_t                   state_q, state_d;
  logic [ENTRIES-1:0][78:0] slot_q;
  logic [ENTRIES-1:0]       sv_q;
  logic [IW-1:0]            victim_q;
  logic                     stale_q, stale_d;
  logic [31:0]              vaddr_q, vaddr_d;
  logic                     store_q, store_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [31:0]              resp_paddr_q, resp_paddr_d;
  logic [2:0]               resp_cattr_q, resp_cattr_d;
  logic [1:0]               resp_exc_q, resp_exc_d;
  logic                     install;

  // Lookup runs on the live request in IDLE and on the latched address otherwise.
  logic [31:0]        lk_va;
  logic               lk_st;
  logic [ENTRIES-1:0] match;
  logic               hit_raw, lk_hit, lk_unm;
  logic [IW-1:0]      hidx;
  logic [78:0]        sel;
  logic [19:0]        lk_pfn;
  logic [2:0]         lk_c;
  logic               lk_v, lk_d;
  logic [31:0]        lk_paddr;
  logic [2:0]         lk_cattr;
  logic [1:0]         lk_exc;

  assign lk_va  = (state_q == IDLE) ? req_vaddr : vaddr_q;
  assign lk_st  = (state_q == IDLE) ? req_store : store_q;
  assign lk_unm = (lk_va[31:30] == 2'b10);

  for (genvar i = 0; i < ENTRIES; i++) begin : g_match
    assign match[i] = sv_q[i] && (slot_q[i][78:60] == lk_va[31:13]) &&
                      ((slot_q[i][0] && slot_q[i][26]) || (slot_q[i][59:52] == cp0_asid));
  end

  // Priority select: lowest matching index wins.
  always_comb begin
    hit_raw = 1'b0;
    hidx    = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (match[i]) begin
        hit_raw = 1'b1;
        hidx    = IW'(i);
      end
    end
  end

  // A flush in the same cycle empties the TLB, so it masks any hit.
  assign lk_hit = hit_raw && !tlbw_flush;
  assign sel    = slot_q[hidx];
  assign lk_pfn = lk_va[12] ? sel[51:32] : sel[25:6];
  assign lk_c   = lk_va[12] ? sel[31:29] : sel[5:3];
  assign lk_v   = lk_va[12] ? sel[27]    : sel[1];
  assign lk_d   = lk_va[12] ? sel[28]    : sel[2];

  // Translation result: unmapped segments bypass, otherwise the selected half.
  always_comb begin
    if (lk_unm) begin
      lk_paddr = {3'b000, lk_va[28:0]};
      lk_cattr = lk_va[29] ? 3'd2 : cp0_k0;
      lk_exc   = 2'd0;
    end else begin
      lk_paddr = {lk_pfn, lk_va[11:0]};
      lk_cattr = lk_c;
      if (!lk_v)              lk_exc = 2'd2;
      else if (lk_st && !lk_d) lk_exc = 2'd3;
      else                     lk_exc = 2'd0;
    end
  end

  // Miss-handling FSM: next state, response fields, install strobe.
  always_comb begin
    state_d      = state_q;
    vaddr_d      = vaddr_q;
    store_d      = store_q;
    stale_d      = stale_q;
    install      = 1'b0;
    resp_valid_d = 1'b0;
    resp_paddr_d = resp_paddr_q;
    resp_cattr_d = resp_cattr_q;
    resp_exc_d   = resp_exc_q;
    case (state_q)
      IDLE: if (req_valid) begin
        vaddr_d = req_vaddr;
        store_d = req_store;
        if (lk_unm || lk_hit) begin
          resp_valid_d = 1'b1;
          resp_paddr_d = lk_paddr;
          resp_cattr_d = lk_cattr;
          resp_exc_d   = lk_exc;
        end else begin
          state_d = QUERY;
        end
      end
      QUERY: begin
        stale_d = tlbw_flush;
        state_d = WAIT;
      end
      WAIT: begin
        if (tlbw_flush) stale_d = 1'b1;
        if (l2_qry_done) begin
          if (stale_q || tlbw_flush) begin
            state_d = QUERY;
          end else if (l2_qry_isexist) begin
            install = 1'b1;
            state_d = REPLAY;
          end else begin
            resp_valid_d = 1'b1;
            resp_paddr_d = '0;
            resp_cattr_d = '0;
            resp_exc_d   = 2'd1;
            state_d      = IDLE;
          end
        end
      end
      REPLAY: begin
        resp_valid_d = 1'b1;
        if (lk_hit) begin
          resp_paddr_d = lk_paddr;
          resp_cattr_d = lk_cattr;
          resp_exc_d   = lk_exc;
        end else begin
          resp_paddr_d = '0;
          resp_cattr_d = '0;
          resp_exc_d   = 2'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      vaddr_q      <= '0;
      store_q      <= 1'b0;
      stale_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_paddr_q <= '0;
      resp_cattr_q <= '0;
      resp_exc_q   <= '0;
    end else begin
      state_q      <= state_d;
      vaddr_q      <= vaddr_d;
      store_q      <= store_d;
      stale_q      <= stale_d;
      resp_valid_q <= resp_valid_d;
      resp_paddr_q <= resp_paddr_d;
      resp_cattr_q <= resp_cattr_d;
      resp_exc_q   <= resp_exc_d;
    end
  end

  // Entry storage: round-robin install, flush clears every valid bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      slot_q   <= '0;
      sv_q     <= '0;
      victim_q <= '0;
    end else begin
      if (install) begin
        slot_q[victim_q] <= l2_qry_tlb;
        sv_q[victim_q]   <= 1'b1;
        victim_q         <= (victim_q == IW'(ENTRIES-1)) ? '0 : victim_q + 1'b1;
      end
      if (tlbw_flush) sv_q <= '0;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign l2_qry_en    = (state_q == QUERY);
  assign l2_qry_vaddr = vaddr_q;
  assign resp_valid   = resp_valid_q;
  assign resp_paddr   = resp_paddr_q;
  assign resp_cattr   = resp_cattr_q;
  assign resp_exc     = resp_exc_q;
endmodule

// File: tb/tb_l1_tlb.sv
// Directed bench for l1_tlb with an inline l2_tlb responder.
module tb_l1_tlb;
  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [31:0] req_vaddr;
  logic        req_store;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_paddr;
  logic [2:0]  resp_cattr;
  logic [1:0]  resp_exc;
  logic [7:0]  cp0_asid;
  logic [2:0]  cp0_k0;
  logic        tlbw_flush;
  logic        l2_qry_en;
  logic [31:0] l2_qry_vaddr;
  logic [78:0] l2_qry_tlb;
  logic        l2_qry_isexist;
  logic        l2_qry_done;

  l1_tlb #(.ENTRIES(4)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_vaddr(req_vaddr), .req_store(req_store), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_paddr(resp_paddr), .resp_cattr(resp_cattr), .resp_exc(resp_exc),
    .cp0_asid(cp0_asid), .cp0_k0(cp0_k0), .tlbw_flush(tlbw_flush),
    .l2_qry_en(l2_qry_en), .l2_qry_vaddr(l2_qry_vaddr), .l2_qry_tlb(l2_qry_tlb),
    .l2_qry_isexist(l2_qry_isexist), .l2_qry_done(l2_qry_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [78:0] l2_ent [2];
  logic        l2_ex  [2];
  int          l2_dly = 10;

  logic        r_got;
  int          r_lat, r_nq;
  logic [31:0] r_paddr, r_qva;
  logic [2:0]  r_cattr;
  logic [1:0]  r_exc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [78:0] mk(input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
                                     input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
                                     input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
    return {vpn2, asid, pfn1, c1, d1, v1, g, pfn0, c0, d0, v0, g};
  endfunction

  // fmode: 0 plain, 1 flush three cycles after the first query, 2 flush with the request.
  task automatic xact(input logic [31:0] va, input logic st, input int fmode);
    int done_at, flush_at, idx, cyc;
    r_got = 1'b0; r_nq = 0; r_lat = 0; done_at = -1; flush_at = -1; cyc = 0;
    @(negedge clk);
    req_vaddr = va; req_store = st; req_valid = 1'b1;
    if (fmode == 2) tlbw_flush = 1'b1;
    while (!r_got && cyc < 200) begin
      cyc++;
      @(posedge clk); #1;
      req_valid = 1'b0; tlbw_flush = 1'b0; l2_qry_done = 1'b0;
      if (resp_valid) begin
        r_got = 1'b1; r_lat = cyc;
        r_paddr = resp_paddr; r_cattr = resp_cattr; r_exc = resp_exc;
      end else begin
        if (l2_qry_en) begin
          r_nq++; r_qva = l2_qry_vaddr; done_at = cyc + l2_dly;
          if (fmode == 1 && r_nq == 1) flush_at = cyc + 3;
        end
        if (cyc == flush_at) tlbw_flush = 1'b1;
        if (cyc == done_at) begin
          idx = (r_nq > 1) ? 1 : 0;
          l2_qry_done = 1'b1; l2_qry_tlb = l2_ent[idx]; l2_qry_isexist = l2_ex[idx];
        end
      end
    end
    if (!r_got) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_vaddr = '0; req_store = 1'b0;
    cp0_asid = 8'd5; cp0_k0 = 3'd3; tlbw_flush = 1'b0;
    l2_qry_tlb = '0; l2_qry_isexist = 1'b0; l2_qry_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rvalid", {31'd0, resp_valid}, 32'd0);
    chk("rst_qry", {31'd0, l2_qry_en}, 32'd0);
    chk("rst_paddr", resp_paddr, 32'd0);
    chk("rst_exc", {30'd0, resp_exc}, 32'd0);

    // kseg1 and kseg0 bypass
    xact(32'hA000_1234, 1'b0, 0);
    chk("k1_lat", r_lat, 1); chk("k1_nq", r_nq, 0);
    chk("k1_paddr", r_paddr, 32'h0000_1234); chk("k1_cattr", {29'd0, r_cattr}, 2);
    chk("k1_exc", {30'd0, r_exc}, 0);
    xact(32'h8000_0010, 1'b0, 0);
    chk("k0_paddr", r_paddr, 32'h0000_0010); chk("k0_cattr", {29'd0, r_cattr}, 3);

    // miss and refill: odd page valid/dirty, even page invalid
    l2_ent[0] = mk(19'h00201, 8'd5, 1'b0, 20'h0ABCD, 3'd1, 1'b0, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1);
    l2_ex[0] = 1'b1;
    xact(32'h0040_3004, 1'b0, 0);
    chk("mr_nq", r_nq, 1); chk("mr_qva", r_qva, 32'h0040_3004); chk("mr_lat", r_lat, 13);
    chk("mr_paddr", r_paddr, 32'h1234_5004); chk("mr_cattr", {29'd0, r_cattr}, 3);
    chk("mr_exc", {30'd0, r_exc}, 0);
    xact(32'h0040_3004, 1'b0, 0);
    chk("rep_lat", r_lat, 1); chk("rep_nq", r_nq, 0); chk("rep_paddr", r_paddr, 32'h1234_5004);
    xact(32'h0040_2008, 1'b0, 0);
    chk("inv_nq", r_nq, 0); chk("inv_exc", {30'd0, r_exc}, 2);

    // odd page clean: store -> modified, load -> ok
    l2_ent[0] = mk(19'h00202, 8'd5, 1'b0, 20'h00000, 3'd0, 1'b0, 1'b0, 20'h00777, 3'd2, 1'b0, 1'b1);
    xact(32'h0040_5000, 1'b1, 0);
    chk("mod_nq", r_nq, 1); chk("mod_exc", {30'd0, r_exc}, 3); chk("mod_paddr", r_paddr, 32'h0077_7000);
    xact(32'h0040_5010, 1'b0, 0);
    chk("ld_lat", r_lat, 1); chk("ld_exc", {30'd0, r_exc}, 0); chk("ld_paddr", r_paddr, 32'h0077_7010);

    // l2 miss -> refill exception
    l2_ex[0] = 1'b0;
    xact(32'h0060_0000, 1'b0, 0);
    chk("rf_nq", r_nq, 1); chk("rf_lat", r_lat, 12); chk("rf_exc", {30'd0, r_exc}, 1);
    chk("rf_paddr", r_paddr, 32'd0);
    l2_ex[0] = 1'b1;

    // ASID mismatch, then global entry
    cp0_asid = 8'd6;
    l2_ent[0] = mk(19'h00400, 8'd5, 1'b0, 20'h11111, 3'd1, 1'b1, 1'b1, 20'h22222, 3'd1, 1'b1, 1'b1);
    xact(32'h0080_0000, 1'b0, 0);
    chk("asid_nq", r_nq, 1); chk("asid_exc", {30'd0, r_exc}, 1);
    l2_ent[0] = mk(19'h00400, 8'd5, 1'b1, 20'h11111, 3'd1, 1'b1, 1'b1, 20'h22222, 3'd1, 1'b1, 1'b1);
    xact(32'h0080_0000, 1'b0, 0);
    chk("glob_nq", r_nq, 1); chk("glob_exc", {30'd0, r_exc}, 0);
    chk("glob_paddr", r_paddr, 32'h1111_1000); chk("glob_cattr", {29'd0, r_cattr}, 1);
    xact(32'h0080_0004, 1'b0, 0);
    chk("glob_hit_nq", r_nq, 0); chk("glob_hit_paddr", r_paddr, 32'h1111_1004);
    cp0_asid = 8'd5;

    // flush in IDLE: previously hitting page misses
    @(negedge clk); tlbw_flush = 1'b1;
    @(negedge clk); tlbw_flush = 1'b0;
    l2_ent[0] = mk(19'h00201, 8'd5, 1'b0, 20'h0ABCD, 3'd1, 1'b0, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1);
    xact(32'h0040_3004, 1'b0, 0);
    chk("fl_idle_nq", r_nq, 1); chk("fl_idle_paddr", r_paddr, 32'h1234_5004);

    // round-robin: four more distinct misses, the last overwrites the first page
    for (int k = 1; k <= 4; k++) begin
      l2_ent[0] = mk(19'h00500 + 19'(k), 8'd5, 1'b0, 20'h00500 + 20'(k), 3'd2, 1'b1, 1'b1,
                     20'h00600, 3'd2, 1'b1, 1'b1);
      xact({13'(19'h00500 + 19'(k)), 19'd0} >> 6, 1'b0, 0);
      chk("rr_fill_nq", r_nq, 1);
    end
    xact(32'h00A0_2000, 1'b0, 0);
    chk("rr_p1_nq", r_nq, 0); chk("rr_p1_paddr", r_paddr, 32'h0050_1000);
    l2_ent[0] = mk(19'h00201, 8'd5, 1'b0, 20'h0ABCD, 3'd1, 1'b0, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1);
    xact(32'h0040_3004, 1'b0, 0);
    chk("rr_evict_nq", r_nq, 1);

    // flush together with a hitting request: treated as a miss
    xact(32'h0040_3004, 1'b0, 2);
    chk("fl_req_nq", r_nq, 1); chk("fl_req_paddr", r_paddr, 32'h1234_5004);

    // flush during WAIT: first result dropped, second query used
    l2_ent[0] = mk(19'h00600, 8'd5, 1'b0, 20'hAAAAA, 3'd1, 1'b1, 1'b1, 20'hAAAAA, 3'd1, 1'b1, 1'b1);
    l2_ent[1] = mk(19'h00600, 8'd5, 1'b0, 20'hBBBBB, 3'd4, 1'b1, 1'b1, 20'hBBBBB, 3'd4, 1'b1, 1'b1);
    l2_ex[1] = 1'b1;
    xact(32'h00C0_0000, 1'b0, 1);
    chk("fl_wait_nq", r_nq, 2); chk("fl_wait_paddr", r_paddr, 32'hBBBB_B000);
    chk("fl_wait_cattr", {29'd0, r_cattr}, 4);
    xact(32'h00C0_0000, 1'b0, 0);
    chk("fl_wait_rep_nq", r_nq, 0); chk("fl_wait_rep_paddr", r_paddr, 32'hBBBB_B000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
